// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types for the scan chain controller: host opcodes, FSM states
// and a small width helper.
package scan_chain_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_ROTATE     = 2'b00,
      OP_LOAD_CHIP  = 2'b01,
      OP_LOAD_CHAIN = 2'b10,
      OP_RSVD       = 2'b11
   } op_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PHI_HI,
      ST_GAP1,
      ST_PHIB_HI,
      ST_GAP2,
      ST_LC_HI,
      ST_LC_LO,
      ST_LCH_SETUP,
      ST_LCH_HOLD,
      ST_DONE
   } state_e;

   // Index width that never collapses to zero for a 1-bit chain.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_phase_timer.sv
// Loadable down-counter timing every phase/gap state of the controller.
// Ports: clk, reset (async, active-high), i_load (restart), o_expire
// (high in the last of PHASE_CYCLES cycles after a load).
module scan_phase_timer #(
   parameter int PHASE_CYCLES = 2,
   parameter int CNT_W        = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   output logic o_expire
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CNT_W'(PHASE_CYCLES - 1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Two-phase scan chain master: ROTATE / LOAD_CHIP / LOAD_CHAIN over a
// valid/ready host port, driving non-overlapping phi/phi_bar pulses.
// Ports: clk, reset (async, active-high); host cmd_valid/cmd_ready/
// cmd_op/cmd_wdata, done/err/rd_data/busy; pads scan_phi, scan_phi_bar,
// scan_data_in, scan_load_chip, scan_load_chain, scan_data_out (in).
// Option: define SCAN_CHAIN_CTRL_AUTO_LOAD_EN to append a load_chip
// pulse to every ROTATE before its done.
module scan_chain_ctrl
   import scan_chain_ctrl_pkg::*;
#(
   parameter int CHAIN_LEN    = 64,
   parameter int PHASE_CYCLES = 2,
   parameter int CNT_W        = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [CHAIN_LEN-1:0] cmd_wdata,
   output logic                 done,
   output logic                 err,
   output logic [CHAIN_LEN-1:0] rd_data,
   output logic                 busy,
   output logic                 scan_phi,
   output logic                 scan_phi_bar,
   output logic                 scan_data_in,
   output logic                 scan_load_chip,
   output logic                 scan_load_chain,
   input  logic                 scan_data_out
);

   localparam int BW = idx_w(CHAIN_LEN);

   state_e                r_state;
   state_e                w_next;
   op_e                   r_op;
   logic [CHAIN_LEN-1:0]  r_shift;
   logic [CHAIN_LEN-1:0]  r_out;
   logic [CHAIN_LEN-1:0]  r_rd;
   logic [BW-1:0]         r_bit;
   logic                  r_sdi;
   logic                  w_expire;
   logic                  w_load;
   logic                  w_last;
   logic                  w_in_pair;
   logic [CHAIN_LEN-1:0]  w_shift_nx;
   logic [CHAIN_LEN-1:0]  w_out_nx;

   assign w_last     = (r_bit == BW'(CHAIN_LEN - 1));
   assign w_shift_nx = r_shift >> 1;
   // New sample enters at the MSB; after the last bit, bit 0 is the first.
   assign w_out_nx   = CHAIN_LEN'({scan_data_out, r_out} >> 1);

   // Any state change restarts the phase timer.
   assign w_load = (w_next != r_state);

   scan_phase_timer #(
      .PHASE_CYCLES (PHASE_CYCLES),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .o_expire (w_expire)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               unique case (cmd_op)
                  OP_ROTATE:     w_next = ST_SETUP;
                  OP_LOAD_CHIP:  w_next = ST_LC_HI;
                  OP_LOAD_CHAIN: w_next = ST_LCH_SETUP;
                  default:       w_next = ST_DONE;
               endcase
            end
         end
         ST_SETUP:     w_next = ST_PHI_HI;
         ST_PHI_HI:    if (w_expire) w_next = ST_GAP1;
         ST_GAP1:      if (w_expire) w_next = ST_PHIB_HI;
         ST_PHIB_HI:   if (w_expire) w_next = ST_GAP2;
         ST_GAP2: begin
            if (w_expire) begin
               if (r_op == OP_LOAD_CHAIN) begin
                  w_next = ST_LCH_HOLD;
               end else if (w_last) begin
`ifdef SCAN_CHAIN_CTRL_AUTO_LOAD_EN
                  w_next = ST_LC_HI;
`else
                  w_next = ST_DONE;
`endif
               end else begin
                  w_next = ST_SETUP;
               end
            end
         end
         ST_LC_HI:     if (w_expire) w_next = ST_LC_LO;
         ST_LC_LO:     if (w_expire) w_next = ST_DONE;
         ST_LCH_SETUP: if (w_expire) w_next = ST_PHI_HI;
         ST_LCH_HOLD:  if (w_expire) w_next = ST_DONE;
         ST_DONE:      w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_op    <= OP_ROTATE;
         r_shift <= '0;
         r_out   <= '0;
         r_rd    <= '0;
         r_bit   <= '0;
         r_sdi   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && cmd_valid) begin
            r_op <= op_e'(cmd_op);
            if (cmd_op == OP_ROTATE) begin
               r_shift <= cmd_wdata;
               r_sdi   <= cmd_wdata[0];
               r_bit   <= '0;
            end
         end
         if (r_state == ST_SETUP) begin
            r_out <= w_out_nx;
         end
         // Advance to the next bit only at the end of its GAP2, so
         // scan_data_in is stable across the whole bit.
         if (r_state == ST_GAP2 && w_expire &&
             r_op == OP_ROTATE && !w_last) begin
            r_shift <= w_shift_nx;
            r_sdi   <= w_shift_nx[0];
            r_bit   <= r_bit + 1'b1;
         end
         if (w_next == ST_DONE && r_state != ST_DONE) begin
            r_sdi <= 1'b0;
         end
         if (r_op == OP_ROTATE && w_next == ST_DONE &&
             (r_state == ST_GAP2 || r_state == ST_LC_LO)) begin
            r_rd <= r_out;
         end
      end
   end

   assign w_in_pair = (r_state == ST_PHI_HI)  || (r_state == ST_GAP1) ||
                      (r_state == ST_PHIB_HI) || (r_state == ST_GAP2);

   assign cmd_ready       = (r_state == ST_IDLE);
   assign busy            = ~cmd_ready;
   assign done            = (r_state == ST_DONE);
   assign err             = done && (r_op == OP_RSVD);
   assign rd_data         = r_rd;
   assign scan_phi        = (r_state == ST_PHI_HI);
   assign scan_phi_bar    = (r_state == ST_PHIB_HI);
   assign scan_data_in    = r_sdi;
   assign scan_load_chip  = (r_state == ST_LC_HI);
   assign scan_load_chain = (r_op == OP_LOAD_CHAIN) &&
                            (w_in_pair || r_state == ST_LCH_SETUP);

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a behavioural two-phase chain
// model and a queue of expected completions.
module tb_scan_chain_ctrl;

   localparam int N       = 8;
   localparam int P       = 2;
   localparam int LAT_ROT = N * (4 * P + 1) + 1;
   localparam int LAT_LC  = 2 * P + 1;
   localparam int LAT_LCH = 6 * P + 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic [N-1:0] cmd_wdata = '0;
   logic         done;
   logic         err;
   logic [N-1:0] rd_data;
   logic         busy;
   logic         scan_phi;
   logic         scan_phi_bar;
   logic         scan_data_in;
   logic         scan_load_chip;
   logic         scan_load_chain;
   logic         scan_data_out;

   scan_chain_ctrl #(
      .CHAIN_LEN    (N),
      .PHASE_CYCLES (P),
      .CNT_W        (8)
   ) dut (
      .clk             (clk),
      .reset           (rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_wdata       (cmd_wdata),
      .done            (done),
      .err             (err),
      .rd_data         (rd_data),
      .busy            (busy),
      .scan_phi        (scan_phi),
      .scan_phi_bar    (scan_phi_bar),
      .scan_data_in    (scan_data_in),
      .scan_load_chip  (scan_load_chip),
      .scan_load_chain (scan_load_chain),
      .scan_data_out   (scan_data_out)
   );

   always #5 clk = ~clk;

   // Behavioural chain: master latches on phi, slave updates on phi_bar.
   logic [N-1:0] chain   = '0;
   logic [N-1:0] master  = '0;
   logic [N-1:0] chip    = '0;
   logic [N-1:0] capture = '0;

   assign scan_data_out = chain[0];

   always @(posedge scan_phi)
      master = scan_load_chain ? capture : {scan_data_in, chain[N-1:1]};
   always @(posedge scan_phi_bar)
      chain = master;
   always @(posedge scan_load_chip)
      chip = chain;

   int checks = 0;
   int errors = 0;

   int phi_cyc = 0, phib_cyc = 0, lc_cyc = 0, lch_cyc = 0, pad_cyc = 0;
   int phi_rise = 0, phib_rise = 0, lch_phi = 0, lch_phib = 0;
   int ovl_errs = 0, gap_errs = 0, low_run = 100;
   logic prev_hi = 1'b0;
   logic scramble = 1'b0;

   always @(negedge clk) begin
      phi_cyc  += int'(scan_phi);
      phib_cyc += int'(scan_phi_bar);
      lc_cyc   += int'(scan_load_chip);
      lch_cyc  += int'(scan_load_chain);
      pad_cyc  += int'(scan_phi | scan_phi_bar | scan_data_in |
                       scan_load_chip | scan_load_chain);
      if (scan_phi && scan_phi_bar) ovl_errs++;
      if (scan_phi || scan_phi_bar) begin
         if (!prev_hi && low_run < P) gap_errs++;
         low_run = 0;
         prev_hi = 1'b1;
      end else begin
         low_run++;
         prev_hi = 1'b0;
      end
   end

   always @(posedge scan_phi) begin
      phi_rise++;
      if (scan_load_chain) lch_phi++;
   end
   always @(posedge scan_phi_bar) begin
      phib_rise++;
      if (scan_load_chain) lch_phib++;
   end

   always @(posedge clk) begin
      #2;
      if (scramble) cmd_wdata = N'($urandom);
   end

   typedef struct {
      logic [N-1:0] rd;
      logic         er;
      int           lat;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      phi_cyc = 0; phib_cyc = 0; lc_cyc = 0; lch_cyc = 0; pad_cyc = 0;
      phi_rise = 0; phib_rise = 0; lch_phi = 0; lch_phib = 0;
   endtask

   // Offer a command, wait for the accepting edge, then drop valid.
   task automatic send(input logic [1:0] op, input logic [N-1:0] wd,
                       input logic hold);
      int w;
      w = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_wdata = wd;
      while (!cmd_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      chk("accept_wait", 64'(w < 500), 64'd1);
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
      clr_mon();
   endtask

   task automatic wait_done();
      int   lat;
      exp_t e;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 2000);
      chk("done_seen", 64'(done), 64'd1);
      chk("sb_size", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("latency", 64'(lat), 64'(e.lat));
         chk("rd_data", 64'(rd_data), 64'(e.rd));
         chk("err", 64'(err), 64'(e.er));
      end
      chk("ready_in_done", 64'(cmd_ready), 64'd0);
      chk("sdi_in_done", 64'(scan_data_in), 64'd0);
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd0);
      chk("ready_after", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      int lat;
      logic [N-1:0] chip_before;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rd", 64'(rd_data), 64'd0);
      chk("rst_pads", 64'({scan_phi, scan_phi_bar, scan_data_in,
                           scan_load_chip, scan_load_chain}), 64'd0);
      rst = 1'b0;

      // ROTATE A5 into a chain holding 3C
      chain = 8'h3C;
      send(2'b00, 8'hA5, 1'b0);
      sb.push_back('{rd: 8'h3C, er: 1'b0, lat: LAT_ROT});
      wait_done();
      chk("rot_chain", 64'(chain), 64'hA5);
      chk("rot_phi_rise", 64'(phi_rise), 64'(N));
      chk("rot_phib_rise", 64'(phib_rise), 64'(N));
      chk("rot_phi_cyc", 64'(phi_cyc), 64'(N * P));
      chk("rot_phib_cyc", 64'(phib_cyc), 64'(N * P));
      chk("rot_no_lc", 64'(lc_cyc), 64'd0);

      // LOAD_CHIP
      send(2'b01, 8'h00, 1'b0);
      sb.push_back('{rd: 8'h3C, er: 1'b0, lat: LAT_LC});
      wait_done();
      chk("lc_cyc", 64'(lc_cyc), 64'(P));
      chk("lc_chip", 64'(chip), 64'hA5);
      chk("lc_no_phi", 64'(phi_rise + phib_rise), 64'd0);

      // LOAD_CHAIN capture 5A, then read it out
      capture = 8'h5A;
      send(2'b10, 8'h00, 1'b0);
      sb.push_back('{rd: 8'h3C, er: 1'b0, lat: LAT_LCH});
      wait_done();
      chk("lch_phi", 64'(lch_phi), 64'd1);
      chk("lch_phib", 64'(lch_phib), 64'd1);
      chk("lch_cyc", 64'(lch_cyc), 64'(5 * P));
      send(2'b00, 8'h00, 1'b0);
      sb.push_back('{rd: 8'h5A, er: 1'b0, lat: LAT_ROT});
      wait_done();
      chk("lch_chain_after", 64'(chain), 64'h00);

      // Reserved opcode
      chip_before = chip;
      send(2'b11, 8'hFF, 1'b0);
      sb.push_back('{rd: 8'h5A, er: 1'b1, lat: 1});
      wait_done();
      chk("rsvd_pads", 64'(pad_cyc), 64'd0);
      chk("rsvd_chip", 64'(chip), 64'(chip_before));

      // Reset during bit 3 PHI_HI
      send(2'b00, 8'hFF, 1'b0);
      lat = 0;
      while (lat < 1 + 3 * (4 * P + 1) + 1) begin
         @(negedge clk);
         lat++;
      end
      chk("mid_phi_hi", 64'(scan_phi), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_phi_drop", 64'(scan_phi), 64'd0);
      chk("mid_ready", 64'(cmd_ready), 64'd1);
      chk("mid_pads", 64'({scan_phi, scan_phi_bar, scan_data_in,
                           scan_load_chip, scan_load_chain}), 64'd0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_no_done", 64'(done), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rd_reset", 64'(rd_data), 64'd0);
      chk("mid_ready_after", 64'(cmd_ready), 64'd1);

      // Valid held through busy with changing wdata
      chain = 8'h11;
      send(2'b00, 8'h96, 1'b1);
      sb.push_back('{rd: 8'h11, er: 1'b0, lat: LAT_ROT});
      scramble = 1'b1;
      wait_done();
      scramble  = 1'b0;
      cmd_wdata = 8'h3C;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("held_accepted", 64'(busy), 64'd1);
      clr_mon();
      sb.push_back('{rd: 8'h96, er: 1'b0, lat: LAT_ROT});
      wait_done();
      chk("held_chain", 64'(chain), 64'h3C);

      chk("nonoverlap", 64'(ovl_errs), 64'd0);
      chk("gap_before_rise", 64'(gap_errs), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
